// File: rtl/candy_issue_ctrl_pkg.sv
// Shared definitions for the candy issue controller: controller states and
// default sizing of the register scoreboard and stall counter.
package candy_issue_ctrl_pkg;

    localparam int unsigned CANDY_NREG        = 16;
    localparam int unsigned CANDY_REG_AW      = 4;
    localparam int unsigned CANDY_STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_CHECK  = 2'd2
    } state_e;

endpackage

// File: rtl/candy_issue_ctrl_if.sv
// Handshake bundle between fetch, decoder, execute/writeback and the issue
// controller. The controller connects through the slave modport; the
// surrounding pipeline drives the master side.
interface candy_issue_ctrl_if #(
    parameter int unsigned NREG        = 16,
    parameter int unsigned REG_AW      = 4,
    parameter int unsigned STALL_CNT_W = 16
);
    logic                   if_valid;
    logic                   if_ready;
    logic                   flush;
    logic                   id_enable;
    logic [REG_AW-1:0]      dec_rs1;
    logic [REG_AW-1:0]      dec_rs2;
    logic [REG_AW-1:0]      dec_rd;
    logic                   dec_re1;
    logic                   dec_re2;
    logic                   dec_we;
    logic                   ex_ready;
    logic                   issue_valid;
    logic                   stall;
    logic                   wb_valid;
    logic [REG_AW-1:0]      wb_rd;
    logic [NREG-1:0]        busy;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output if_valid, flush, dec_rs1, dec_rs2, dec_rd, dec_re1, dec_re2,
               dec_we, ex_ready, wb_valid, wb_rd,
        input  if_ready, id_enable, issue_valid, stall, busy, stall_cnt
    );

    modport slave (
        input  if_valid, flush, dec_rs1, dec_rs2, dec_rd, dec_re1, dec_re2,
               dec_we, ex_ready, wb_valid, wb_rd,
        output if_ready, id_enable, issue_valid, stall, busy, stall_cnt
    );
endinterface

// File: rtl/candy_issue_ctrl_scoreboard.sv
// Register busy-bit scoreboard. A set (issue of a writing instruction) wins
// over a same-cycle clear (writeback) of the same register.
// Build option: CANDY_ISSUE_WB_BYPASS_EN masks the register retiring this
// cycle out of busy_eff_o so a waiting instruction can issue immediately.
module candy_issue_ctrl_scoreboard #(
    parameter int unsigned NREG   = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_i,
    input  logic [REG_AW-1:0] set_idx_i,
    input  logic              clr_i,
    input  logic [REG_AW-1:0] clr_idx_i,
    output logic [NREG-1:0]   busy_o,
    output logic [NREG-1:0]   busy_eff_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] clr_mask;

    // Next busy vector: clear first, then set, so set wins on a collision
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
    end

    // Busy vector register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // One-hot mask of the register being retired this cycle
    always_comb begin
        clr_mask = '0;
        if (clr_i) begin
            clr_mask[clr_idx_i] = 1'b1;
        end
    end

`ifdef CANDY_ISSUE_WB_BYPASS_EN
    assign busy_eff_o = busy_q & ~clr_mask;
`else
    assign busy_eff_o = busy_q;
`endif

    assign busy_o = busy_q;

endmodule

// File: rtl/candy_issue_ctrl.sv
// Issue controller for the 24-bit candy core: sequences fetch -> decode ->
// hazard check -> issue, tracks register hazards via the scoreboard and counts
// stall cycles (saturating).
// Build option: CANDY_ISSUE_WB_BYPASS_EN (see candy_issue_ctrl_scoreboard).
module candy_issue_ctrl
    import candy_issue_ctrl_pkg::*;
#(
    parameter int unsigned NREG        = CANDY_NREG,
    parameter int unsigned REG_AW      = CANDY_REG_AW,
    parameter int unsigned STALL_CNT_W = CANDY_STALL_CNT_W
) (
    input logic               clk,
    input logic               rst,
    candy_issue_ctrl_if.slave bus
);

    state_e                 state_q;
    state_e                 state_d;
    logic [NREG-1:0]        busy_eff;
    logic [NREG-1:0]        busy_vec;
    logic                   haz;
    logic                   issue;
    logic                   stall;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    candy_issue_ctrl_scoreboard #(
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_i      (issue & bus.dec_we),
        .set_idx_i  (bus.dec_rd),
        .clr_i      (bus.wb_valid),
        .clr_idx_i  (bus.wb_rd),
        .busy_o     (busy_vec),
        .busy_eff_o (busy_eff)
    );

    // RAW on either enabled source, WAW on an enabled destination
    always_comb begin
        haz = (bus.dec_re1 & busy_eff[bus.dec_rs1])
            | (bus.dec_re2 & busy_eff[bus.dec_rs2])
            | (bus.dec_we  & busy_eff[bus.dec_rd]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (bus.if_valid) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_CHECK;
            ST_CHECK:  if (!haz && bus.ex_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs; a flush cycle accepts, issues and stalls nothing
    always_comb begin
        bus.if_ready  = (state_q == ST_IDLE) && !bus.flush;
        bus.id_enable = (state_q == ST_IDLE) && bus.if_valid && !bus.flush;
        issue         = (state_q == ST_CHECK) && !haz && bus.ex_ready && !bus.flush;
        stall         = (state_q == ST_CHECK) && (haz || !bus.ex_ready) && !bus.flush;
    end

    // Saturating stall counter next value
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.issue_valid = issue;
    assign bus.stall       = stall;
    assign bus.busy        = busy_vec;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_candy_issue_ctrl.sv
// Testbench for candy_issue_ctrl: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_candy_issue_ctrl;

    localparam int unsigned NREG        = 16;
    localparam int unsigned REG_AW      = 4;
    localparam int unsigned STALL_CNT_W = 4;
    localparam int          CNT_MAX     = (1 << STALL_CNT_W) - 1;
`ifdef CANDY_ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    candy_issue_ctrl_if #(.NREG(NREG), .REG_AW(REG_AW), .STALL_CNT_W(STALL_CNT_W)) bus ();

    candy_issue_ctrl #(.NREG(NREG), .REG_AW(REG_AW), .STALL_CNT_W(STALL_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_issue  = 0;

    // Reference model: age = cycles since acceptance (-1 when nothing pending),
    // per-register busy flags and the stall count as a plain integer.
    int age  = -1;
    bit mbusy [NREG];
    int mcnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: compare DUT outputs with the model at negedge, advance the model
    task automatic step();
        bit          beff [NREG];
        bit          haz, idle, chk, e_issue, e_stall;
        logic [31:0] ebusy;
        @(negedge clk);
        if (bus.issue_valid === 1'b1) n_issue++;
        if (rst) begin
            age  = -1;
            mcnt = 0;
            for (int i = 0; i < NREG; i++) mbusy[i] = 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++)
                beff[i] = mbusy[i] && !(BYP && bus.wb_valid && (int'(bus.wb_rd) == i));
            haz = (bus.dec_re1 && beff[bus.dec_rs1]) || (bus.dec_re2 && beff[bus.dec_rs2])
               || (bus.dec_we && beff[bus.dec_rd]);
            idle    = (age < 0);
            chk     = (age >= 2);
            e_issue = chk && !haz && bus.ex_ready && !bus.flush;
            e_stall = chk && (haz || !bus.ex_ready) && !bus.flush;
            ebusy = '0;
            for (int i = 0; i < NREG; i++) ebusy[i] = mbusy[i];
            check_eq("if_ready",    32'(bus.if_ready),    32'(idle && !bus.flush));
            check_eq("id_enable",   32'(bus.id_enable),   32'(idle && bus.if_valid && !bus.flush));
            check_eq("issue_valid", 32'(bus.issue_valid), 32'(e_issue));
            check_eq("stall",       32'(bus.stall),       32'(e_stall));
            check_eq("busy",        32'(bus.busy),        ebusy);
            check_eq("stall_cnt",   32'(bus.stall_cnt),   32'(mcnt));
            if (bus.flush)        age = -1;
            else if (idle)        age = bus.if_valid ? 1 : -1;
            else if (age < 2)     age = age + 1;
            else if (e_issue)     age = -1;
            if (bus.wb_valid) mbusy[bus.wb_rd] = 1'b0;
            if (e_issue && bus.dec_we) mbusy[bus.dec_rd] = 1'b1;
            if (e_stall && mcnt < CNT_MAX) mcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_inst(input int rs1, input int rs2, input int rd,
                            input bit re1, input bit re2, input bit we);
        bus.dec_rs1 = REG_AW'(rs1);
        bus.dec_rs2 = REG_AW'(rs2);
        bus.dec_rd  = REG_AW'(rd);
        bus.dec_re1 = re1;
        bus.dec_re2 = re2;
        bus.dec_we  = we;
    endtask

    // Accept + decode cycles; the instruction is then in the check phase
    task automatic launch();
        bus.if_valid = 1'b1;
        step();
        bus.if_valid = 1'b0;
        step();
    endtask

    initial begin
        int r;
        rst          = 1'b1;
        bus.if_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = '0;
        set_inst(0, 0, 0, 1'b0, 1'b0, 1'b0);
        steps(2);
        rst = 1'b0;
        #1;
        check_eq("rst_if_ready",  32'(bus.if_ready),    32'd1);
        check_eq("rst_busy",      32'(bus.busy),        32'd0);
        check_eq("rst_stall_cnt", 32'(bus.stall_cnt),   32'd0);
        check_eq("rst_stall",     32'(bus.stall),       32'd0);
        check_eq("rst_issue",     32'(bus.issue_valid), 32'd0);

        // 1: R-type, no hazard, issue two cycles after accept
        set_inst(1, 2, 3, 1'b1, 1'b1, 1'b1);
        launch();
        step();
        check_eq("t1_busy",   32'(bus.busy), 32'h0008);
        check_eq("t1_issues", 32'(n_issue),  32'd1);

        // 2: RAW on r3, resolved by writeback of r3
        set_inst(3, 0, 0, 1'b1, 1'b0, 1'b0);
        launch();
        steps(3);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd3;
        step();
        bus.wb_valid = 1'b0;
        if (!BYP) step();
        #1;
        check_eq("t2_issues",    32'(n_issue),       32'd2);
        check_eq("t2_stall_cnt", 32'(bus.stall_cnt), BYP ? 32'd3 : 32'd4);
        check_eq("t2_busy",      32'(bus.busy),      32'h0000);

        // 3: WAW on r5; collision of set and clear on r5 leaves it busy
        set_inst(0, 0, 5, 1'b0, 1'b0, 1'b1);
        launch();
        step();
        set_inst(0, 0, 5, 1'b0, 1'b0, 1'b1);
        launch();
        steps(2);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd5;
        step();
        bus.wb_valid = 1'b0;
        if (!BYP) step();
        #1;
        check_eq("t3_busy",      32'(bus.busy),      32'h0020);
        check_eq("t3_stall_cnt", 32'(bus.stall_cnt), BYP ? 32'd5 : 32'd7);
        bus.wb_valid = 1'b1;
        step();
        bus.wb_valid = 1'b0;

        // 4: S-type held off by ex_ready for 3 check cycles; stray clear of r2
        set_inst(4, 6, 9, 1'b1, 1'b1, 1'b0);
        bus.ex_ready = 1'b0;
        launch();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 4'd2;
        step();
        bus.wb_valid = 1'b0;
        steps(2);
        bus.ex_ready = 1'b1;
        step();
        #1;
        check_eq("t4_stall_cnt", 32'(bus.stall_cnt), BYP ? 32'd8 : 32'd10);
        check_eq("t4_busy",      32'(bus.busy),      32'h0000);
        check_eq("t4_issues",    32'(n_issue),       32'd5);

        // 5: flush while stalled on r7
        set_inst(0, 0, 7, 1'b0, 1'b0, 1'b1);
        launch();
        step();
        set_inst(7, 0, 0, 1'b1, 1'b0, 1'b0);
        launch();
        steps(2);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        #1;
        check_eq("t5_if_ready",  32'(bus.if_ready),  32'd1);
        check_eq("t5_busy",      32'(bus.busy),      32'h0080);
        check_eq("t5_issues",    32'(n_issue),       32'd6);
        check_eq("t5_stall_cnt", 32'(bus.stall_cnt), BYP ? 32'd10 : 32'd12);

        // 6: saturate the counter, then reset in the middle of CHECK
        launch();
        steps(20);
        check_eq("t6_sat", 32'(bus.stall_cnt), 32'hF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_eq("t6_if_ready",  32'(bus.if_ready),  32'd1);
        check_eq("t6_busy",      32'(bus.busy),      32'h0000);
        check_eq("t6_stall_cnt", 32'(bus.stall_cnt), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 499) == 0);
            bus.flush    = ($urandom_range(0, 29) == 0);
            bus.if_valid = $urandom_range(0, 1);
            bus.ex_ready = ($urandom_range(0, 3) != 0);
            if (age < 0) begin
                set_inst($urandom_range(0, NREG-1), $urandom_range(0, NREG-1),
                         $urandom_range(0, NREG-1), $urandom_range(0, 1),
                         $urandom_range(0, 1), $urandom_range(0, 1));
            end
            bus.wb_valid = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, NREG-1);
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < NREG; k++) begin
                    if (mbusy[(r + k) % NREG]) begin
                        r = (r + k) % NREG;
                        break;
                    end
                end
            end
            bus.wb_rd = REG_AW'(r);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
